// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame controller: state encoding and parity sense.
package uart_rx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_par_calc.sv
// Combinational expected parity bit for the assembled byte under the selected parity sense.
module uart_rx_par_calc
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Even parity makes the total count of ones even; odd parity inverts that bit.
    assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start/data/parity/stop sequencing, byte assembly and status pulses.
// Optional UART_RX_ERR_STATUS_EN adds sticky error status bits with a clear input.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic [PRESC_W-1:0]    edge_cnt,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic                  sampled_bit,
`ifdef UART_RX_ERR_STATUS_EN
    input  logic                  err_clr,
    output logic [2:0]            err_status,
`endif
    output logic                  cnt_en,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch
);

    state_t state;
    state_t next_state;
    logic   bit_end;
    logic   last_data;
    logic   exp_par;
    logic   par_flag;
    logic   dv_next;
    logic   pe_next;
    logic   se_next;
    logic   sg_next;

    assign bit_end   = (edge_cnt == (Prescale - PRESC_W'(1)));
    assign last_data = (bit_cnt == BIT_CNT_W'(DATA_WIDTH));

    uart_rx_par_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_par_calc (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (exp_par)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (!RX_IN) next_state = ST_START;
            end
            ST_START: begin
                if (bit_end) next_state = sampled_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && last_data) next_state = PAR_EN ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) next_state = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Counter and sampler run for the whole frame; pulse requests are registered below.
    always_comb begin
        cnt_en      = (state != ST_IDLE);
        dat_samp_en = (state != ST_IDLE);
        sg_next     = (state == ST_START) && bit_end && sampled_bit;
        se_next     = (state == ST_STOP) && bit_end && !sampled_bit;
        pe_next     = (state == ST_STOP) && bit_end && par_flag;
        dv_next     = (state == ST_STOP) && bit_end && sampled_bit && !par_flag;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P_DATA      <= '0;
            par_flag    <= 1'b0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            data_valid  <= dv_next;
            par_err     <= pe_next;
            stp_err     <= se_next;
            strt_glitch <= sg_next;
            if ((state == ST_DATA) && bit_end) begin
                P_DATA <= {sampled_bit, P_DATA[DATA_WIDTH-1:1]};
            end
            if ((state == ST_PARITY) && bit_end && (sampled_bit != exp_par)) begin
                par_flag <= 1'b1;
            end else if ((state == ST_STOP) && bit_end) begin
                par_flag <= 1'b0;
            end
        end
    end

`ifdef UART_RX_ERR_STATUS_EN
    // A clear coinciding with a new error still leaves that error's bit set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_status <= 3'b000;
        end else begin
            err_status <= (err_clr ? 3'b000 : err_status) | {sg_next, se_next, pe_next};
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm with behavioural edge/bit counter and majority sampler models.
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;
    localparam int BW = 4;

    typedef struct packed {
        logic          dv;
        logic          pe;
        logic          se;
        logic          sg;
        logic [DW-1:0] pd;
    } ev_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          pen;
        logic          ptyp;
        logic          pbit;
        logic          stop;
        logic          glitch;
        int            presc;
        ev_t           exp;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [PW-1:0] Prescale;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          sampled_bit;
    logic          cnt_en;
    logic          dat_samp_en;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          strt_glitch;
    logic [2:0]    smp;
`ifdef UART_RX_ERR_STATUS_EN
    logic          err_clr = 1'b0;
    logic [2:0]    err_status;
`endif

    int  nvec = 0;
    int  nerr = 0;
    ev_t evq[$];

    uart_rx_fsm #(
        .DATA_WIDTH(DW),
        .PRESC_W   (PW),
        .BIT_CNT_W (BW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .Prescale    (Prescale),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .sampled_bit (sampled_bit),
`ifdef UART_RX_ERR_STATUS_EN
        .err_clr     (err_clr),
        .err_status  (err_status),
`endif
        .cnt_en      (cnt_en),
        .dat_samp_en (dat_samp_en),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .strt_glitch (strt_glitch)
    );

    always #5 CLK = ~CLK;

    // Edge/bit counter as seen by the controller.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == Prescale - PW'(1)) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BW'(1);
        end else begin
            edge_cnt <= edge_cnt + PW'(1);
        end
    end

    // Three mid-bit samples, majority-voted.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            smp <= 3'b000;
        end else if (dat_samp_en) begin
            if (edge_cnt == (Prescale >> 1) - PW'(1)) smp[0] <= RX_IN;
            if (edge_cnt == (Prescale >> 1))          smp[1] <= RX_IN;
            if (edge_cnt == (Prescale >> 1) + PW'(1)) smp[2] <= RX_IN;
        end
    end
    assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    always @(negedge CLK) begin
        if (!RST && (data_valid || par_err || stp_err || strt_glitch)) begin
            evq.push_back({data_valid, par_err, stp_err, strt_glitch, P_DATA});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic ev_t mk_ev(input logic dv, pe, se, sg, input logic [DW-1:0] pd);
        ev_t e;
        e.dv = dv; e.pe = pe; e.se = se; e.sg = sg; e.pd = pd;
        return e;
    endfunction

    // Frame outcome from the line-level rules: parity counts ones, stop must be high.
    function automatic ev_t ref_frame(input logic [DW-1:0] data, input logic pen, ptyp, pbit,
                                      stop, glitch, input logic [DW-1:0] prev_pd);
        int  ones;
        logic bad_par;
        if (glitch) return mk_ev(1'b0, 1'b0, 1'b0, 1'b1, prev_pd);
        ones    = $countones(data) + int'(pbit);
        bad_par = pen && ((ones % 2) != int'(ptyp));
        return mk_ev(!bad_par && stop, bad_par, !stop, 1'b0, data);
    endfunction

    function automatic logic good_parity(input logic [DW-1:0] data, input logic ptyp);
        return logic'(($countones(data) + int'(ptyp)) % 2);
    endfunction

    task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_frame(input logic [DW-1:0] data, input logic pen, pbit, stop,
                               input int presc, input int nbits);
        logic [15:0] bits;
        int          len;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[i+1] = data[i];
        len = DW + 1;
        if (pen) begin
            bits[len] = pbit;
            len++;
        end
        bits[len] = stop;
        len++;
        if (nbits > 0 && nbits < len) len = nbits;
        for (int i = 0; i < len; i++) begin
            RX_IN = bits[i];
            tick(presc);
        end
        RX_IN = 1'b1;
    endtask

    task automatic expect_one(input string nm, input ev_t e);
        check_eq({nm, " count"}, 32'(evq.size()), 32'd1);
        if (evq.size() > 0) check_eq({nm, " event"}, 32'(evq[0]), 32'(e));
        evq.delete();
    endtask

    task automatic apply(input string nm, input vec_t v);
        PAR_EN   = v.pen;
        PAR_TYP  = v.ptyp;
        Prescale = PW'(v.presc);
        tick(2);
        if (v.glitch) begin
            RX_IN = 1'b0;
            tick(3);
            RX_IN = 1'b1;
            tick(v.presc * 2);
        end else begin
            drive_frame(v.data, v.pen, v.pbit, v.stop, v.presc, 0);
        end
        tick(6);
        expect_one(nm, v.exp);
    endtask

    vec_t tbl[8];
    vec_t rv;
    ev_t  e0;
    logic [DW-1:0] model_pd;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8,  mk_ev(1, 0, 0, 0, 8'hA5)};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8,  mk_ev(1, 0, 0, 0, 8'h3C)};
        tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8,  mk_ev(0, 1, 0, 0, 8'h3C)};
        tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8,  mk_ev(0, 0, 0, 1, 8'h3C)};
        tbl[4] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8,  mk_ev(0, 0, 1, 0, 8'h81)};
        tbl[5] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8,  mk_ev(0, 1, 1, 0, 8'h81)};
        tbl[6] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16, mk_ev(1, 0, 0, 0, 8'h5A)};
        tbl[7] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32, mk_ev(1, 0, 0, 0, 8'hC3)};

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = PW'(8);
        tick(3);
        check_eq("rst cnt_en", 32'(cnt_en), 0);
        check_eq("rst dat_samp_en", 32'(dat_samp_en), 0);
        check_eq("rst P_DATA", 32'(P_DATA), 0);
        check_eq("rst pulses", 32'({data_valid, par_err, stp_err, strt_glitch}), 0);
        RST = 1'b0;
        tick(3);
        check_eq("idle cnt_en", 32'(cnt_en), 0);

        for (int i = 0; i < 8; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Back-to-back frames at Prescale=16.
        PAR_EN = 1'b0; Prescale = PW'(16);
        tick(2);
        drive_frame(8'h55, 1'b0, 1'b0, 1'b1, 16, 0);
        drive_frame(8'hAA, 1'b0, 1'b0, 1'b1, 16, 0);
        tick(6);
        check_eq("b2b count", 32'(evq.size()), 2);
        if (evq.size() > 1) begin
            check_eq("b2b first", 32'(evq[0]), 32'(mk_ev(1, 0, 0, 0, 8'h55)));
            check_eq("b2b second", 32'(evq[1]), 32'(mk_ev(1, 0, 0, 0, 8'hAA)));
        end
        evq.delete();

        // Reset during data bit 4, then a clean frame.
        Prescale = PW'(8);
        tick(2);
        drive_frame(8'h96, 1'b0, 1'b0, 1'b1, 8, 5);
        RX_IN = 1'b1;
        RX_IN = 1'b0;
        tick(4);
        check_eq("pre-rst busy", 32'(cnt_en), 1);
        RST = 1'b1;
        #1;
        check_eq("midrst cnt_en", 32'(cnt_en), 0);
        check_eq("midrst dat_samp_en", 32'(dat_samp_en), 0);
        check_eq("midrst P_DATA", 32'(P_DATA), 0);
        check_eq("midrst pulses", 32'({data_valid, par_err, stp_err, strt_glitch}), 0);
        RX_IN = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(5);
        check_eq("post-rst events", 32'(evq.size()), 0);
        check_eq("post-rst cnt_en", 32'(cnt_en), 0);
        evq.delete();
        drive_frame(8'h0F, 1'b0, 1'b0, 1'b1, 8, 0);
        tick(6);
        expect_one("after rst", mk_ev(1, 0, 0, 0, 8'h0F));

        // Randomized frames against the reference model.
        model_pd = 8'h0F;
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel       = int'($urandom_range(0, 2));
            rv.presc  = (sel == 0) ? 8 : (sel == 1) ? 16 : 32;
            rv.data   = DW'($urandom);
            rv.pen    = 1'($urandom);
            rv.ptyp   = 1'($urandom);
            rv.pbit   = good_parity(rv.data, rv.ptyp) ^ ($urandom_range(0, 3) == 0);
            rv.stop   = ($urandom_range(0, 6) != 0);
            rv.glitch = ($urandom_range(0, 9) == 0);
            rv.exp    = ref_frame(rv.data, rv.pen, rv.ptyp, rv.pbit, rv.stop, rv.glitch, model_pd);
            model_pd  = rv.exp.pd;
            apply($sformatf("rnd%0d", i), rv);
        end

        e0 = mk_ev(0, 0, 0, 0, 8'h00);
        check_eq("final idle", 32'({cnt_en, data_valid}), 32'({e0.dv, e0.dv}));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
